// File: rtl/return_addr_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_addr_stack
// Description : Hardware call/return address stack. A push stores a return
//               PC, a pop consumes the current top-of-stack. All requests are
//               qualified by hold (pipeline stall). Sticky overflow/underflow
//               flags record illegal accesses until err_clr.
//               Optional build macro RAS_CIRCULAR_EN turns the storage into a
//               circular buffer so a push while full overwrites the oldest
//               entry instead of being dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module return_addr_stack #(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] top,
    output logic [PTR_W:0]    count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W:0]    r_count;
    logic [ADDR_W-1:0] r_top;
    logic              r_ovf;
    logic              r_unf;

    logic [PTR_W-1:0]  w_base;
    logic [PTR_W-1:0]  w_cnt_lo;
    logic [PTR_W-1:0]  w_top_idx;
    logic [PTR_W-1:0]  w_rd_idx;
    logic              w_p;
    logic              w_q;
    logic              w_empty;
    logic              w_full;

    logic [PTR_W:0]    w_count_nxt;
    logic [ADDR_W-1:0] w_top_nxt;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_ovf_set;
    logic              w_unf_set;

`ifdef RAS_CIRCULAR_EN
    logic [PTR_W-1:0]  r_base;
    logic [PTR_W-1:0]  w_base_nxt;
    assign w_base = r_base;
`else
    assign w_base = '0;
`endif

    // Stall qualification and derived indices; all indices are relative to
    // the oldest entry and wrap modulo DEPTH through PTR_W-bit arithmetic.
    assign w_p       = push & ~hold;
    assign w_q       = pop  & ~hold;
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_cnt);
    assign w_cnt_lo  = r_count[PTR_W-1:0];
    assign w_top_idx = w_base + w_cnt_lo - PTR_W'(1);
    assign w_rd_idx  = w_base + w_cnt_lo - PTR_W'(2);

    // Next-state decode for push / pop / replace and error detection.
    always_comb begin
        w_count_nxt = r_count;
        w_top_nxt   = r_top;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_base + w_cnt_lo;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
`ifdef RAS_CIRCULAR_EN
        w_base_nxt  = r_base;
`endif
        if (w_p && w_q) begin
            if (w_empty) begin
                // Pop of an empty stack is flagged, the push still lands.
                w_wr_en     = 1'b1;
                w_wr_idx    = w_base;
                w_count_nxt = (PTR_W+1)'(1);
                w_top_nxt   = push_data;
                w_unf_set   = 1'b1;
            end else begin
                // Replace top in place; never an overflow, even when full.
                w_wr_en   = 1'b1;
                w_wr_idx  = w_top_idx;
                w_top_nxt = push_data;
            end
        end else if (w_p) begin
            if (!w_full) begin
                w_wr_en     = 1'b1;
                w_wr_idx    = w_base + w_cnt_lo;
                w_count_nxt = r_count + (PTR_W+1)'(1);
                w_top_nxt   = push_data;
            end else begin
                w_ovf_set = 1'b1;
`ifdef RAS_CIRCULAR_EN
                // Oldest slot becomes the newest; count stays at DEPTH.
                w_wr_en    = 1'b1;
                w_wr_idx   = r_base;
                w_base_nxt = r_base + PTR_W'(1);
                w_top_nxt  = push_data;
`endif
            end
        end else if (w_q) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else if (r_count == (PTR_W+1)'(1)) begin
                w_count_nxt = '0;
                w_top_nxt   = '0;
            end else begin
                w_count_nxt = r_count - (PTR_W+1)'(1);
                w_top_nxt   = r_mem[w_rd_idx];
            end
        end
    end

    // Control state: occupancy, registered top and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_top   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_top   <= w_top_nxt;
            r_ovf   <= w_ovf_set | (r_ovf & ~err_clr);
            r_unf   <= w_unf_set | (r_unf & ~err_clr);
        end
    end

`ifdef RAS_CIRCULAR_EN
    // Base pointer of the circular buffer (index of the oldest entry).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_base <= '0;
        end else begin
            r_base <= w_base_nxt;
        end
    end
`endif

    // Storage array; contents are never observable while empty, so no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    assign top       = r_top;
    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire
